// File: rtl/comparator_bist.sv
// Self-test driver for the 2-bit magnitude comparator: walks all 16 operand pairs and checks gt/lt/eq.
// Optional BIST_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module comparator_bist #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       A1,
    output logic       A0,
    output logic       B1,
    output logic       B0,
    input  logic       A_gt_B,
    input  logic       A_lt_B,
    input  logic       A_eq_B,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_fail_vec
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] CHECK  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    logic [1:0] state;
    logic [3:0] vec;
    logic [3:0] cnt;

    logic       exp_gt;
    logic       exp_lt;
    logic       exp_eq;
    logic       mismatch;
    logic       last_vec;
    logic [4:0] err_next;

    assign A1 = vec[3];
    assign A0 = vec[2];
    assign B1 = vec[1];
    assign B0 = vec[0];

    assign exp_gt = (vec[3:2] >  vec[1:0]);
    assign exp_lt = (vec[3:2] <  vec[1:0]);
    assign exp_eq = (vec[3:2] == vec[1:0]);

    // Any deviation counts, so multi-hot and all-zero results fail too.
    assign mismatch = ({A_gt_B, A_lt_B, A_eq_B} != {exp_gt, exp_lt, exp_eq});
    assign err_next = (mismatch && err_count != 5'd16) ? err_count + 5'd1 : err_count;

`ifdef BIST_STOP_ON_FAIL_EN
    assign last_vec = mismatch || (vec == 4'd15);
`else
    assign last_vec = (vec == 4'd15);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            vec            <= 4'd0;
            cnt            <= 4'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 5'd0;
            first_fail_vec <= 4'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= SETTLE;
                        vec            <= 4'd0;
                        cnt            <= SETTLE_INIT;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_count      <= 5'd0;
                        first_fail_vec <= 4'd0;
                    end
                end
                SETTLE: begin
                    if (cnt <= 4'd1) begin
                        state <= CHECK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                CHECK: begin
                    err_count <= err_next;
                    if (mismatch && err_count == 5'd0) begin
                        first_fail_vec <= vec;
                    end
                    if (last_vec) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 5'd0);
                    end else begin
                        state <= SETTLE;
                        vec   <= vec + 4'd1;
                        cnt   <= SETTLE_INIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
